// File: rtl/gs_uart_pkg.sv
// Shared constants and drain-FSM encoding for the UART TX/RX byte paths.
package gs_uart_pkg;

  localparam int unsigned UART_BYTE_W       = 8;
  localparam int unsigned HANDSHAKE_TIMEOUT = 2;

  typedef logic [1:0] drain_state_t;

  localparam drain_state_t StIdle   = 2'd0;
  localparam drain_state_t StSend   = 2'd1;
  localparam drain_state_t StWaitHi = 2'd2;
  localparam drain_state_t StWaitLo = 2'd3;

endpackage

// File: rtl/gs_uart_tx_fifo_if.sv
// Bus-wrapper side of the TX FIFO: push port, status flags and the uart_tx en/busy handshake.
interface gs_uart_tx_fifo_if #(
  parameter int unsigned AddrW = 4
);
  import gs_uart_pkg::*;

  logic                   wr_en;
  logic [UART_BYTE_W-1:0] wr_data;
  logic                   clr_ovf;
  logic                   full;
  logic                   empty;
  logic [AddrW:0]         level;
  logic                   overflow;
  logic                   tx_en;
  logic [UART_BYTE_W-1:0] tx_data;
  logic                   tx_busy;

  modport master (
    output wr_en, wr_data, clr_ovf, tx_busy,
    input  full, empty, level, overflow, tx_en, tx_data
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf, tx_busy,
    output full, empty, level, overflow, tx_en, tx_data
  );

endinterface

// File: rtl/gs_sync_fifo.sv
// Synchronous FIFO with registered level/full/empty and a registered read-data port.
module gs_sync_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AddrW:0]   level_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   level_q, level_d;
  logic             full_q, empty_q;
  logic [Width-1:0] rdata_q;
  logic             do_push, do_pop;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (do_pop && !do_push) begin
      level_d = level_q - 1'b1;
    end
  end

  // No reset on storage so it can map to distributed RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      rdata_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rdata_q  <= mem_q[rd_ptr_q];
      end
      level_q <= level_d;
      full_q  <= (level_d == (AddrW + 1)'(Depth));
      empty_q <= (level_d == '0);
    end
  end

  assign rdata_o = rdata_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/gs_uart_tx_fifo.sv
// TX byte FIFO plus drain FSM feeding uart_tx one byte per en/busy handshake.
module gs_uart_tx_fifo
  import gs_uart_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  gs_uart_tx_fifo_if.slave bus
);

  localparam int unsigned HsCntW = (HANDSHAKE_TIMEOUT > 1) ? $clog2(HANDSHAKE_TIMEOUT) : 1;

  drain_state_t           state_q, state_d;
  logic [HsCntW-1:0]      hs_cnt_q, hs_cnt_d;
  logic                   tx_en_q;
  logic                   ovf_q, ovf_d;
  logic                   pop;
  logic                   fifo_full, fifo_empty;
  logic [AddrW:0]         fifo_level;
  logic [UART_BYTE_W-1:0] fifo_rdata;

  gs_sync_fifo #(
    .Depth(Depth),
    .Width(UART_BYTE_W),
    .AddrW(AddrW)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (bus.wr_en),
    .wdata_i(bus.wr_data),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    hs_cnt_d = hs_cnt_q;
    pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !bus.tx_busy) begin
          pop     = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        hs_cnt_d = '0;
        state_d  = StWaitHi;
      end
      StWaitHi: begin
        // A serialiser that never raises busy must not stall the queue forever.
        if (bus.tx_busy) begin
          state_d = StWaitLo;
        end else if (hs_cnt_q == HsCntW'(HANDSHAKE_TIMEOUT - 1)) begin
          state_d = StIdle;
        end else begin
          hs_cnt_d = hs_cnt_q + 1'b1;
        end
      end
      StWaitLo: begin
        if (!bus.tx_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Setting the sticky flag wins over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.wr_en && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      hs_cnt_q <= '0;
      tx_en_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hs_cnt_q <= hs_cnt_d;
      tx_en_q  <= pop;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.level    = fifo_level;
  assign bus.overflow = ovf_q;
  assign bus.tx_en    = tx_en_q;
  assign bus.tx_data  = fifo_rdata;

endmodule

// File: tb/tb_gs_uart_tx_fifo.sv
// Randomised bench for gs_uart_tx_fifo against a queue-based model, plus directed scenarios.
module tb_gs_uart_tx_fifo;
  import gs_uart_pkg::*;

  localparam int unsigned Depth = 16;
  localparam int unsigned AddrW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gs_uart_tx_fifo_if #(.AddrW(AddrW)) bus ();

  gs_uart_tx_fifo #(
    .Depth(Depth),
    .AddrW(AddrW)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // uart_tx stand-in: busy rises the cycle after tx_en, lasts a random number of cycles.
  logic uart_busy = 1'b0;
  logic force_busy = 1'b0;
  int   busy_left = 0;
  int   busy_lo = 1, busy_hi = 4;
  bit   allow_ignore = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_busy <= 1'b0;
      busy_left <= 0;
    end else if (uart_busy) begin
      if (busy_left <= 1) uart_busy <= 1'b0;
      busy_left <= busy_left - 1;
    end else if (bus.tx_en) begin
      if (!(allow_ignore && $urandom_range(7, 0) == 0)) begin
        uart_busy <= 1'b1;
        busy_left <= int'($urandom_range(busy_hi, busy_lo));
      end
    end
  end

  assign bus.tx_busy = uart_busy | force_busy;

  // Reference model: byte queue plus "transmitter engaged" bookkeeping in edges since a pop.
  byte unsigned mq[$];
  bit           m_free = 1'b1;
  int           m_age  = 0;
  bit           m_hi   = 1'b0;
  bit           m_ovf  = 1'b0;
  bit           m_tx_en = 1'b0;
  logic [7:0]   m_tx_data = 8'h00;
  bit           m_pop, m_busy, m_drop;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_free = 1'b1; m_age = 0; m_hi = 1'b0;
      m_ovf = 1'b0; m_tx_en = 1'b0; m_tx_data = 8'h00;
    end else begin
      m_busy = bus.tx_busy;
      m_pop  = m_free && (mq.size() > 0) && !m_busy;
      if (!m_free) begin
        m_age++;
        if (m_age >= 2) begin
          if (m_hi) begin
            if (!m_busy) m_free = 1'b1;
          end else if (m_busy) begin
            m_hi = 1'b1;
          end else if (m_age >= 1 + int'(HANDSHAKE_TIMEOUT)) begin
            m_free = 1'b1;
          end
        end
      end
      if (m_pop) begin
        m_tx_data = mq.pop_front();
        m_free = 1'b0; m_age = 0; m_hi = 1'b0;
      end
      m_tx_en = m_pop;
      m_drop  = 1'b0;
      if (bus.wr_en) begin
        if (mq.size() < Depth) mq.push_back(bus.wr_data);
        else m_drop = 1'b1;
      end
      if (m_drop) m_ovf = 1'b1;
      else if (bus.clr_ovf) m_ovf = 1'b0;
    end
  end

  // Per-cycle compare and capture of transmitted bytes.
  byte unsigned got[$];

  initial forever begin
    @(negedge clk);
    check("level", bus.level, mq.size());
    check("full", bus.full, mq.size() == Depth);
    check("empty", bus.empty, mq.size() == 0);
    check("overflow", bus.overflow, m_ovf);
    check("tx_en", bus.tx_en, m_tx_en);
    check("tx_data", bus.tx_data, m_tx_data);
    if (rst_n && bus.tx_en === 1'b1) begin
      got.push_back(bus.tx_data);
      check("busy_at_en", bus.tx_busy, 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((mq.size() != 0 || !m_free || uart_busy) && n < 600) begin
      step();
      n++;
    end
    if (n >= 600) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: drain timeout, level %0d, expected 0", name, bus.level);
    end
  endtask

  initial begin
    byte unsigned exp_q[$];
    int pct[4] = '{70, 15, 95, 40};

    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.clr_ovf = 1'b0;

    // 1: reset with wr_en held high
    bus.wr_en = 1'b1; bus.wr_data = 8'h5A;
    repeat (4) begin
      step();
      check("t1_level", bus.level, 0);
      check("t1_empty", bus.empty, 1);
      check("t1_full", bus.full, 0);
      check("t1_tx_en", bus.tx_en, 0);
      check("t1_ovf", bus.overflow, 0);
    end
    bus.wr_en = 1'b0;
    rst_n = 1'b1;
    step();
    check("t1_level_post", bus.level, 0);

    // 2: single byte, busy 10 cycles
    busy_lo = 10; busy_hi = 10;
    got.delete();
    push(8'h41);
    check("t2_level1", bus.level, 1);
    check("t2_en_early", bus.tx_en, 0);
    step();
    check("t2_en", bus.tx_en, 1);
    check("t2_data", bus.tx_data, 8'h41);
    step();
    check("t2_en_drop", bus.tx_en, 0);
    wait_drain("t2");
    check("t2_count", got.size(), 1);
    check("t2_level0", bus.level, 0);

    // 3: fill with busy held
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    check("t3_level16", bus.level, 16);
    check("t3_full", bus.full, 1);
    push(8'h10);
    check("t3_ovf", bus.overflow, 1);
    check("t3_level_hold", bus.level, 16);
    bus.clr_ovf = 1'b1; step(); bus.clr_ovf = 1'b0;
    check("t3_ovf_clr", bus.overflow, 0);

    // 4: drain in order
    busy_lo = 1; busy_hi = 4;
    got.delete();
    force_busy = 1'b0;
    wait_drain("t4");
    check("t4_count", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) check("t4_order", got[i], i);

    // 5: push while full in the same cycle as a pop (second fill wraps pointers)
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    check("t5_full", bus.full, 1);
    got.delete();
    bus.wr_en = 1'b1; bus.wr_data = 8'hAA; force_busy = 1'b0;
    step();
    bus.wr_en = 1'b0;
    check("t5_level", bus.level, 16);
    check("t5_ovf", bus.overflow, 0);
    wait_drain("t5");
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h20 + i));
    exp_q.push_back(8'hAA);
    check("t5_count", got.size(), 17);
    for (int i = 0; i < 17 && i < got.size(); i++) check("t5_order", got[i], exp_q[i]);

    // 6: reset during WAIT_LO with level 5
    busy_lo = 12; busy_hi = 12;
    force_busy = 1'b1;
    for (int i = 0; i < 6; i++) push(8'(8'h50 + i));
    force_busy = 1'b0;
    repeat (3) step();
    check("t6_level5", bus.level, 5);
    check("t6_busy", bus.tx_busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_level", bus.level, 0);
    check("t6_rst_empty", bus.empty, 1);
    check("t6_rst_full", bus.full, 0);
    check("t6_rst_en", bus.tx_en, 0);
    check("t6_rst_data", bus.tx_data, 8'h00);
    check("t6_rst_ovf", bus.overflow, 0);
    step(); step();
    rst_n = 1'b1;
    repeat (5) begin
      step();
      check("t6_no_stale_en", bus.tx_en, 0);
    end

    // 7: randomised traffic with handshake timeouts
    busy_lo = 1; busy_hi = 5; allow_ignore = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 500; c++) begin
        bus.wr_en   = ($urandom_range(99, 0) < pct[p]);
        bus.wr_data = 8'($urandom);
        bus.clr_ovf = ($urandom_range(15, 0) == 0);
        if (p == 2 && c == 250) rst_n = 1'b0;
        if (p == 2 && c == 252) rst_n = 1'b1;
        step();
      end
    end
    bus.wr_en = 1'b0; bus.clr_ovf = 1'b0;
    wait_drain("t7");
    check("t7_empty", bus.empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
